// File: rtl/color_tx_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : color_tx_encoder
//  Description : Serialises bytes into colour symbols for a downstream colour
//                decoder. Each byte becomes a frame of four symbols, MSB dibit
//                first. Each symbol is held on led with tx high for SYM_CYCLES
//                cycles and followed by GAP_CYCLES dark cycles. One byte can
//                wait in a holding buffer so that frames run back to back.
//  Ports       : p_clock    - clock, rising edge active
//                p_reset_n  - asynchronous active-low reset
//                data_in    - byte to transmit
//                data_valid - data_in is valid
//                data_ready - a byte can be accepted (holding buffer empty)
//                led        - colour pattern (registered)
//                tx         - led holds a valid symbol (registered)
//                busy       - frame in progress or byte buffered
//  Revision    : 1.0 - initial release
// ============================================================================
module color_tx_encoder #(
    parameter int SYM_CYCLES = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic       p_clock,
    input  logic       p_reset_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [2:0] led,
    output logic       tx,
    output logic       busy
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SYMBOL = 2'd1;
    localparam logic [1:0] c_ST_GAP    = 2'd2;

    localparam logic [7:0] c_SYM_LAST   = 8'(SYM_CYCLES - 1);
    localparam logic [7:0] c_GAP_LAST   = 8'(GAP_CYCLES - 1);
    localparam logic [1:0] c_DIBIT_LAST = 2'd3;

    logic [1:0] r_state;
    logic [7:0] r_cyc_cnt;
    logic [1:0] r_dibit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_buf;
    logic       r_buf_full;
    logic [2:0] r_led;
    logic       r_tx;

    logic [1:0] w_next_state;
    logic [7:0] w_next_cyc_cnt;
    logic [1:0] w_next_dibit_cnt;
    logic [7:0] w_next_shift;
    logic [7:0] w_next_buf;
    logic       w_next_buf_full;
    logic [2:0] w_next_led;
    logic       w_next_tx;
    logic       w_xfer;

    assign data_ready = ~r_buf_full;
    assign w_xfer     = data_valid & ~r_buf_full;
    assign busy       = (r_state != c_ST_IDLE) | r_buf_full;
    assign led        = r_led;
    assign tx         = r_tx;

    // State and datapath registers
    always_ff @(posedge p_clock or negedge p_reset_n) begin
        if (!p_reset_n) begin
            r_state     <= c_ST_IDLE;
            r_cyc_cnt   <= 8'd0;
            r_dibit_cnt <= 2'd0;
            r_shift     <= 8'd0;
            r_buf       <= 8'd0;
            r_buf_full  <= 1'b0;
            r_led       <= 3'b000;
            r_tx        <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cyc_cnt   <= w_next_cyc_cnt;
            r_dibit_cnt <= w_next_dibit_cnt;
            r_shift     <= w_next_shift;
            r_buf       <= w_next_buf;
            r_buf_full  <= w_next_buf_full;
            r_led       <= w_next_led;
            r_tx        <= w_next_tx;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_next_state     = r_state;
        w_next_cyc_cnt   = r_cyc_cnt;
        w_next_dibit_cnt = r_dibit_cnt;
        w_next_shift     = r_shift;
        w_next_buf       = r_buf;
        w_next_buf_full  = r_buf_full;

        case (r_state)
            c_ST_IDLE: begin
                if (w_xfer) begin
                    w_next_shift     = data_in;
                    w_next_state     = c_ST_SYMBOL;
                    w_next_cyc_cnt   = 8'd0;
                    w_next_dibit_cnt = 2'd0;
                end
            end

            c_ST_SYMBOL: begin
                if (r_cyc_cnt == c_SYM_LAST) begin
                    w_next_state   = c_ST_GAP;
                    w_next_cyc_cnt = 8'd0;
                end else begin
                    w_next_cyc_cnt = r_cyc_cnt + 8'd1;
                end
                if (w_xfer) begin
                    w_next_buf      = data_in;
                    w_next_buf_full = 1'b1;
                end
            end

            c_ST_GAP: begin
                if (r_cyc_cnt != c_GAP_LAST) begin
                    w_next_cyc_cnt = r_cyc_cnt + 8'd1;
                    if (w_xfer) begin
                        w_next_buf      = data_in;
                        w_next_buf_full = 1'b1;
                    end
                end else begin
                    w_next_cyc_cnt   = 8'd0;
                    // Wraps to 0 after the fourth symbol, ready for the next frame
                    w_next_dibit_cnt = r_dibit_cnt + 2'd1;
                    if (r_dibit_cnt != c_DIBIT_LAST) begin
                        w_next_state = c_ST_SYMBOL;
                        w_next_shift = {r_shift[5:0], 2'b00};
                        if (w_xfer) begin
                            w_next_buf      = data_in;
                            w_next_buf_full = 1'b1;
                        end
                    end else if (r_buf_full) begin
                        // Buffered byte starts with no idle cycle in between
                        w_next_shift    = r_buf;
                        w_next_buf_full = 1'b0;
                        w_next_state    = c_ST_SYMBOL;
                    end else if (w_xfer) begin
                        // Byte arriving on the frame-end edge bypasses the buffer
                        w_next_shift = data_in;
                        w_next_state = c_ST_SYMBOL;
                    end else begin
                        w_next_state = c_ST_IDLE;
                    end
                end
            end

            default: begin
                w_next_state     = c_ST_IDLE;
                w_next_cyc_cnt   = 8'd0;
                w_next_dibit_cnt = 2'd0;
            end
        endcase
    end

    // Outputs are computed from the upcoming state so that led/tx can be
    // registered and still change on the same edge as the state.
    always_comb begin
        w_next_tx  = (w_next_state == c_ST_SYMBOL);
        w_next_led = 3'b000;
        if (w_next_tx) begin
            case (w_next_shift[7:6])
                2'd0:    w_next_led = 3'b111;
                2'd1:    w_next_led = 3'b100;
                2'd2:    w_next_led = 3'b010;
                default: w_next_led = 3'b001;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_color_tx_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_color_tx_encoder
//  Description : Self-checking bench for color_tx_encoder with SYM_CYCLES=4,
//                GAP_CYCLES=2. A table of bytes with hand-computed colour
//                sequences drives single frames; hand-written sequences cover
//                back-to-back frames, frame-end transfers, a full buffer,
//                asynchronous reset and a run of random bytes. A monitor
//                compares {tx, led} every cycle against an expected stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_color_tx_encoder;

    localparam int SYM = 4;
    localparam int GAP = 2;

    logic       p_clock;
    logic       p_reset_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [2:0] led;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Expected {tx, led} per cycle; an empty queue means the line is dark.
    logic [3:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic [2:0] l0;
        logic [2:0] l1;
        logic [2:0] l2;
        logic [2:0] l3;
    } vec_t;

    vec_t tbl[5];

    color_tx_encoder #(
        .SYM_CYCLES(SYM),
        .GAP_CYCLES(GAP)
    ) dut (
        .p_clock   (p_clock),
        .p_reset_n (p_reset_n),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .led       (led),
        .tx        (tx),
        .busy      (busy)
    );

    initial p_clock = 1'b0;
    always #5 p_clock = ~p_clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] colour(input logic [1:0] d);
        case (d)
            2'd0:    return 3'b111;
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    task automatic push_sym(input logic [2:0] l);
        for (int i = 0; i < SYM; i++) exp_q.push_back({1'b1, l});
        for (int i = 0; i < GAP; i++) exp_q.push_back(4'b0000);
    endtask

    task automatic push_frame(input logic [2:0] l0, input logic [2:0] l1,
                              input logic [2:0] l2, input logic [2:0] l3);
        push_sym(l0);
        push_sym(l1);
        push_sym(l2);
        push_sym(l3);
    endtask

    // Per-cycle output monitor, sampled mid-cycle
    always @(negedge p_clock) begin : mon
        logic [3:0] e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 4'b0000;
        chk("led_tx", 32'({tx, led}), 32'(e));
    end

    // Presents a byte for one edge; called just after a rising edge.
    task automatic do_xfer(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        @(posedge p_clock);
        #1;
        data_valid = 1'b0;
        data_in    = 8'($urandom);
    endtask

    task automatic drain_and_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge p_clock);
            n++;
        end
        chk("drain_timeout", 32'(n < 200), 32'd1);
        @(posedge p_clock);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(data_ready), 32'd1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!data_ready && n < 100) begin
            @(posedge p_clock);
            #1;
            n++;
        end
        chk("ready_timeout", 32'(n < 100), 32'd1);
    endtask

    initial begin
        tbl[0] = '{8'h1B, 3'b111, 3'b100, 3'b010, 3'b001};
        tbl[1] = '{8'hE4, 3'b001, 3'b010, 3'b100, 3'b111};
        tbl[2] = '{8'h00, 3'b111, 3'b111, 3'b111, 3'b111};
        tbl[3] = '{8'hFF, 3'b001, 3'b001, 3'b001, 3'b001};
        tbl[4] = '{8'h6C, 3'b100, 3'b010, 3'b001, 3'b111};

        p_reset_n  = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;
        #1;
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_tx", 32'(tx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(data_ready), 32'd1);

        // Reset held across clock edges, with valid asserted
        data_valid = 1'b1;
        repeat (2) @(posedge p_clock);
        #1;
        data_valid = 1'b0;
        chk("rst_hold_busy", 32'(busy), 32'd0);
        p_reset_n = 1'b1;

        // Single frames from the table, busy through the whole frame
        for (int i = 0; i < 5; i++) begin
            chk("tbl_ready", 32'(data_ready), 32'd1);
            do_xfer(tbl[i].data);
            push_frame(tbl[i].l0, tbl[i].l1, tbl[i].l2, tbl[i].l3);
            for (int c = 0; c < 4 * (SYM + GAP) - 1; c++) begin
                chk("tbl_busy", 32'(busy), 32'd1);
                @(posedge p_clock);
                #1;
            end
            drain_and_idle();
        end

        // Back-to-back: 0xFF then 0x00 on the next edge
        do_xfer(8'hFF);
        push_frame(3'b001, 3'b001, 3'b001, 3'b001);
        chk("b2b_ready_first", 32'(data_ready), 32'd1);
        do_xfer(8'h00);
        push_frame(3'b111, 3'b111, 3'b111, 3'b111);
        chk("b2b_ready_low", 32'(data_ready), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        begin
            int n = 0;
            while (!data_ready && n < 100) begin
                @(posedge p_clock);
                #1;
                n++;
            end
            chk("b2b_ready_low_cycles", 32'(n), 32'd23);
        end
        drain_and_idle();

        // Transfer on the edge ending the last gap, buffer empty
        do_xfer(8'h1B);
        push_frame(3'b111, 3'b100, 3'b010, 3'b001);
        repeat (23) @(posedge p_clock);
        #1;
        chk("edge_ready", 32'(data_ready), 32'd1);
        chk("edge_busy", 32'(busy), 32'd1);
        do_xfer(8'hE4);
        push_frame(3'b001, 3'b010, 3'b100, 3'b111);
        drain_and_idle();

        // Third byte offered while the buffer is full is refused
        do_xfer(8'hA5);
        push_frame(3'b010, 3'b010, 3'b100, 3'b100);
        do_xfer(8'h3C);
        push_frame(3'b111, 3'b001, 3'b001, 3'b111);
        data_in    = 8'hC3;
        data_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge p_clock);
            #1;
            chk("full_ready", 32'(data_ready), 32'd0);
        end
        data_valid = 1'b0;
        drain_and_idle();

        // Asynchronous reset mid-frame with a byte buffered
        do_xfer(8'h1B);
        push_frame(3'b111, 3'b100, 3'b010, 3'b001);
        do_xfer(8'hE4);
        push_frame(3'b001, 3'b010, 3'b100, 3'b111);
        repeat (9) @(posedge p_clock);
        #3;
        p_reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_led", 32'(led), 32'd0);
        chk("arst_tx", 32'(tx), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(data_ready), 32'd1);
        repeat (3) @(posedge p_clock);
        #1;
        p_reset_n = 1'b1;
        // First edge after release takes the byte
        do_xfer(8'h6C);
        push_frame(3'b100, 3'b010, 3'b001, 3'b111);
        drain_and_idle();

        // Random bytes, kept back to back through the holding buffer
        for (int k = 0; k < 20; k++) begin
            logic [7:0] b;
            b = 8'($urandom);
            wait_ready();
            do_xfer(b);
            push_frame(colour(b[7:6]), colour(b[5:4]), colour(b[3:2]), colour(b[1:0]));
        end
        drain_and_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/color_tx_encoder.md
COLOR_TX_ENCODER -- requirements
Module: color_tx_encoder

Interface
REQ-001 The block SHALL have parameter SYM_CYCLES, default 16: clock cycles each colour symbol is held with tx high (legal range 1..255).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4: dark cycles after every symbol with tx low (legal range 1..255).
REQ-003 The block SHALL have port p_clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port p_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port data_in, input, 8 bits: byte to transmit.
REQ-006 The block SHALL have port data_valid, input, 1 bit: data_in is valid.
REQ-007 The block SHALL have port data_ready, output, 1 bit: block can accept a byte; a transfer occurs on a rising edge with data_valid=1 and data_ready=1.
REQ-008 The block SHALL have port led, output, 3 bits: colour pattern driven to the downstream colour decoder.
REQ-009 The block SHALL have port tx, output, 1 bit: led holds a valid symbol.
REQ-010 The block SHALL have port busy, output, 1 bit: a frame is in progress or a byte is buffered.

Function
REQ-011 Each byte SHALL be sent as a frame of 4 symbols, dibits in MSB-first order: data[7:6], data[5:4], data[3:2], data[1:0].
REQ-012 Dibit-to-led mapping SHALL be 0 -> 3'b111 (white), 1 -> 3'b100 (red), 2 -> 3'b010 (green), 3 -> 3'b001 (blue), so the decoder's col output equals the dibit.
REQ-013 The FSM SHALL have states IDLE, SYMBOL and GAP.
REQ-014 In IDLE, led SHALL be 3'b000 and tx SHALL be 0.
REQ-015 In SYMBOL, led SHALL be the mapped dibit and tx SHALL be 1 for exactly SYM_CYCLES cycles, then the FSM SHALL go to GAP.
REQ-016 In GAP, led SHALL be 3'b000 and tx SHALL be 0 for exactly GAP_CYCLES cycles.
REQ-017 At the end of GAP, if fewer than 4 symbols of the frame have been sent, the FSM SHALL return to SYMBOL with the next dibit.
REQ-018 Frame length SHALL be exactly 4*(SYM_CYCLES+GAP_CYCLES) cycles; every symbol, including the last, SHALL be followed by a GAP.
REQ-019 led and tx SHALL be registered outputs, with no combinational path from inputs.
REQ-020 The block SHALL contain one shift register (frame in flight) and one 8-bit holding buffer with a full flag.
REQ-021 data_ready SHALL equal NOT buf_full (combinational from state only).
REQ-022 A transfer in IDLE SHALL load the shift register directly and enter SYMBOL; the first symbol SHALL appear on led/tx in the cycle after the transfer edge.
REQ-023 A transfer while not IDLE SHALL store the byte in the buffer and set buf_full.
REQ-024 At the edge ending the last GAP of a frame, if buf_full, the buffer SHALL move to the shift register, buf_full SHALL clear and the FSM SHALL enter SYMBOL with no idle cycle.
REQ-025 At that same edge, if the buffer is empty and a transfer occurs, the byte SHALL load directly into the shift register and enter SYMBOL with no idle cycle.
REQ-026 At that same edge, with no buffered byte and no transfer, the FSM SHALL enter IDLE.
REQ-027 busy SHALL be 1 whenever state != IDLE or buf_full=1.
REQ-028 data_in SHALL be ignored when no transfer occurs; data_valid while data_ready=0 SHALL not affect state.
REQ-029 Cycle counters SHALL be 8 bits, and the dibit counter SHALL be 2 bits and wrap after the 4th symbol.

Reset
REQ-030 While p_reset_n=0, regardless of p_clock: state=IDLE, led=3'b000, tx=0, busy=0, buf_full=0, data_ready=1, all counters 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame and discard any buffered byte.
REQ-032 After reset release, the first transfer SHALL be accepted at the first rising edge.

Verification (SYM_CYCLES=4, GAP_CYCLES=2)
REQ-033 Transfer 0x1B in IDLE -> led sequence 111,100,010,001, each for 4 cycles with tx=1, each followed by 2 cycles of 000 with tx=0; then IDLE; total 24 cycles; busy high for those 24 cycles.
REQ-034 Transfer 0xFF then 0x00 on the next edge -> data_ready low from that edge until the buffer drains; 4 blue symbols, then 4 white symbols starting at cycle 25; no idle cycle between frames.
REQ-035 Transfer at the last GAP edge with the buffer empty -> the new frame's first symbol immediately follows the gap.
REQ-036 Third byte offered while the buffer is full -> data_ready=0, byte not taken, current and buffered frames unchanged.
REQ-037 p_reset_n low at cycle 10 of a frame with a byte buffered -> led=000, tx=0, busy=0, data_ready=1 immediately, asynchronously to p_clock; no further symbols.
REQ-038 Connected to the downstream colour decoder: col equals each dibit of random bytes over 1000 frames.
